rgb_frame_pwm_sink: RTL and testbench

//  Frame sink for the 25-LED RGB matrix. Upstream pattern logic streams per-LED colour words in over a

---
 rtl/rgb_matrix_pkg.sv | 45 ++++
 rtl/rgb_pwm_timebase.sv | 37 +++
 rtl/rgb_frame_pwm_sink.sv | 138 +++++++++++++
 tb/tb_rgb_frame_pwm_sink.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_matrix_pkg.sv
// Shared constants, colour word layout and write-FSM states for the 25-LED RGB matrix.
package rgb_matrix_pkg;

  localparam int unsigned N_LEDS_DFLT     = 25;
  localparam int unsigned DEPTH_BITS_DFLT = 4;
  localparam int unsigned PRESCALE_DFLT   = 256;
  localparam int unsigned ADDR_W          = 5;

  // One pin's "off" level; pins are active-low.
  localparam logic LED_OFF = 1'b1;

  typedef struct packed {
    logic [DEPTH_BITS_DFLT-1:0] r;
    logic [DEPTH_BITS_DFLT-1:0] g;
    logic [DEPTH_BITS_DFLT-1:0] b;
  } rgb_t;

  typedef enum logic {
    ST_ACCEPT  = 1'b0,
    ST_PENDING = 1'b1
  } wr_state_e;

  function automatic logic [DEPTH_BITS_DFLT-1:0] rgb_red(input rgb_t c);
    return c.r;
  endfunction

  function automatic logic [DEPTH_BITS_DFLT-1:0] rgb_green(input rgb_t c);
    return c.g;
  endfunction

  function automatic logic [DEPTH_BITS_DFLT-1:0] rgb_blue(input rgb_t c);
    return c.b;
  endfunction

  function automatic rgb_t rgb_pack(input logic [DEPTH_BITS_DFLT-1:0] r,
                                    input logic [DEPTH_BITS_DFLT-1:0] g,
                                    input logic [DEPTH_BITS_DFLT-1:0] b);
    rgb_t c;
    c.r = r;
    c.g = g;
    c.b = b;
    return c;
  endfunction

endpackage

// File: rtl/rgb_pwm_timebase.sv
// PWM timebase: prescaler feeding a 0..2^DEPTH_BITS-2 step counter, with step and period-end strobes.
module rgb_pwm_timebase #(
  parameter int unsigned DEPTH_BITS = 4,
  parameter int unsigned PRESCALE   = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [DEPTH_BITS-1:0] o_pwm,
  output logic                  o_step_c,
  output logic                  o_period_end_c
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]      PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [DEPTH_BITS-1:0] PWM_MAX = DEPTH_BITS'((1 << DEPTH_BITS) - 2);

  logic [PRE_W-1:0]      r_pre;
  logic [DEPTH_BITS-1:0] r_pwm;

  assign o_step_c       = (r_pre == PRE_MAX);
  assign o_period_end_c = o_step_c && (r_pwm == PWM_MAX);
  assign o_pwm          = r_pwm;

  // Level 2^D-1 must stay lit all period, so pwm never reaches it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre <= '0;
      r_pwm <= '0;
    end else begin
      r_pre <= o_step_c ? '0 : r_pre + PRE_W'(1);
      if (o_step_c) begin
        r_pwm <= (r_pwm == PWM_MAX) ? '0 : r_pwm + DEPTH_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/rgb_frame_pwm_sink.sv
// Double-buffered frame sink for the RGB matrix; frames are swapped in only at PWM period boundaries.
module rgb_frame_pwm_sink
  import rgb_matrix_pkg::*;
#(
  parameter int unsigned N_LEDS     = N_LEDS_DFLT,
  parameter int unsigned DEPTH_BITS = DEPTH_BITS_DFLT,
  parameter int unsigned PRESCALE   = PRESCALE_DFLT
) (
  input  logic                    main_clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [3*DEPTH_BITS-1:0] wr_rgb,
  input  logic                    wr_last,
  output logic [N_LEDS-1:0]       R,
  output logic [N_LEDS-1:0]       G,
  output logic [N_LEDS-1:0]       B,
  output logic                    frame_shown,
  output logic                    err_addr
);

  localparam int unsigned WORD_W = 3 * DEPTH_BITS;
  localparam int unsigned R_LSB  = 2 * DEPTH_BITS;
  localparam int unsigned G_LSB  = DEPTH_BITS;
  localparam int unsigned B_LSB  = 0;

  wr_state_e             r_state;
  wr_state_e             w_state_nxt;
  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_swap_c;
  logic                  r_wr_ready;
  logic                  r_err_addr;
  logic [WORD_W-1:0]     r_back  [N_LEDS];
  logic [WORD_W-1:0]     r_front [N_LEDS];
  logic [DEPTH_BITS-1:0] w_pwm;
  logic                  w_unused_step_c;
  logic                  w_period_end_c;
  logic [N_LEDS-1:0]     r_r;
  logic [N_LEDS-1:0]     r_g;
  logic [N_LEDS-1:0]     r_b;
  logic [N_LEDS-1:0]     w_r_nxt;
  logic [N_LEDS-1:0]     w_g_nxt;
  logic [N_LEDS-1:0]     w_b_nxt;

  rgb_pwm_timebase #(
    .DEPTH_BITS (DEPTH_BITS),
    .PRESCALE   (PRESCALE)
  ) u_timebase (
    .i_clk          (main_clk),
    .i_rst          (reset),
    .o_pwm          (w_pwm),
    .o_step_c       (w_unused_step_c),
    .o_period_end_c (w_period_end_c)
  );

  assign w_in_range = (32'(wr_addr) < N_LEDS);

  // Write FSM state register
  always_ff @(posedge main_clk) begin
    if (reset) begin
      r_state    <= ST_ACCEPT;
      r_wr_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ready <= (w_state_nxt == ST_ACCEPT);
    end
  end

  // Write FSM next state; a closed frame waits in PENDING for the next period end
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_swap_c    = 1'b0;
    case (r_state)
      ST_ACCEPT: begin
        w_accept = wr_valid && r_wr_ready;
        if (w_accept && wr_last) begin
          w_state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_period_end_c) begin
          w_swap_c    = 1'b1;
          w_state_nxt = ST_ACCEPT;
        end
      end
      default: w_state_nxt = ST_ACCEPT;
    endcase
  end

  // Back buffer fill, sticky address error, and parallel swap into the front buffer
  always_ff @(posedge main_clk) begin
    if (reset) begin
      r_back     <= '{default: '0};
      r_front    <= '{default: '0};
      r_err_addr <= 1'b0;
    end else begin
      if (w_accept && w_in_range) begin
        r_back[wr_addr] <= wr_rgb;
      end
      if (w_accept && !w_in_range) begin
        r_err_addr <= 1'b1;
      end
      if (w_swap_c) begin
        r_front <= r_back;
      end
    end
  end

  for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_led
    assign w_r_nxt[gi] = ~(r_front[gi][R_LSB +: DEPTH_BITS] > w_pwm);
    assign w_g_nxt[gi] = ~(r_front[gi][G_LSB +: DEPTH_BITS] > w_pwm);
    assign w_b_nxt[gi] = ~(r_front[gi][B_LSB +: DEPTH_BITS] > w_pwm);
  end

  // Pin registers
  always_ff @(posedge main_clk) begin
    if (reset) begin
      r_r <= {N_LEDS{LED_OFF}};
      r_g <= {N_LEDS{LED_OFF}};
      r_b <= {N_LEDS{LED_OFF}};
    end else begin
      r_r <= w_r_nxt;
      r_g <= w_g_nxt;
      r_b <= w_b_nxt;
    end
  end

  assign R           = r_r;
  assign G           = r_g;
  assign B           = r_b;
  assign wr_ready    = r_wr_ready;
  assign err_addr    = r_err_addr;
  assign frame_shown = w_swap_c && !reset;

endmodule

// File: tb/tb_rgb_frame_pwm_sink.sv
// Bench for rgb_frame_pwm_sink: directed scenarios plus random traffic against a cycle-count based model.
module tb_rgb_frame_pwm_sink;
  import rgb_matrix_pkg::*;

  localparam int unsigned NL  = 25;
  localparam int unsigned P   = 2;
  localparam int unsigned LV  = 15;
  localparam int unsigned PER = P * LV;

  logic              main_clk = 1'b0;
  logic              reset    = 1'b1;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr  = '0;
  logic [11:0]       wr_rgb   = '0;
  logic              wr_last  = 1'b0;
  logic              wr_ready;
  logic [NL-1:0]     R;
  logic [NL-1:0]     G;
  logic [NL-1:0]     B;
  logic              frame_shown;
  logic              err_addr;

  int checks = 0;
  int errors = 0;

  always #5 main_clk = ~main_clk;

  rgb_frame_pwm_sink #(
    .N_LEDS     (NL),
    .DEPTH_BITS (4),
    .PRESCALE   (P)
  ) dut (
    .main_clk    (main_clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_rgb      (wr_rgb),
    .wr_last     (wr_last),
    .R           (R),
    .G           (G),
    .B           (B),
    .frame_shown (frame_shown),
    .err_addr    (err_addr)
  );

  // Reference model: t counts clocks since reset release, so pwm = (t/P) mod 15.
  logic [11:0]   m_back  [NL];
  logic [11:0]   m_front [NL];
  logic          m_pending = 1'b0;
  logic          m_err     = 1'b0;
  logic          m_valid   = 1'b0;
  int            m_t       = 0;
  logic [NL-1:0] m_R = '1;
  logic [NL-1:0] m_G = '1;
  logic [NL-1:0] m_B = '1;

  task automatic model_step();
    int pwm;
    logic acc;
    if (reset) begin
      for (int i = 0; i < NL; i++) begin
        m_back[i]  = '0;
        m_front[i] = '0;
      end
      m_R = '1; m_G = '1; m_B = '1;
      m_pending = 1'b0;
      m_err     = 1'b0;
      m_t       = 0;
    end else begin
      pwm = (m_t / P) % LV;
      for (int i = 0; i < NL; i++) begin
        m_R[i] = !(int'(m_front[i][11:8]) > pwm);
        m_G[i] = !(int'(m_front[i][7:4])  > pwm);
        m_B[i] = !(int'(m_front[i][3:0])  > pwm);
      end
      acc = wr_valid && !m_pending;
      if (m_pending && (m_t % PER == PER - 1)) begin
        for (int i = 0; i < NL; i++) m_front[i] = m_back[i];
        m_pending = 1'b0;
      end
      if (acc) begin
        if (wr_addr < NL) m_back[wr_addr] = wr_rgb;
        else              m_err = 1'b1;
        if (wr_last) m_pending = 1'b1;
      end
      m_t++;
    end
    m_valid = 1'b1;
  endtask

  initial forever begin
    @(posedge main_clk);
    model_step();
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge main_clk);
    if (m_valid) begin
      chk("R", 64'(R), 64'(m_R));
      chk("G", 64'(G), 64'(m_G));
      chk("B", 64'(B), 64'(m_B));
      chk("wr_ready", 64'(wr_ready), 64'(!m_pending));
      chk("frame_shown", 64'(frame_shown),
          64'(!reset && m_pending && (m_t % PER == PER - 1)));
      chk("err_addr", 64'(err_addr), 64'(m_err));
    end
  end

  task automatic tick();
    @(posedge main_clk);
    #1;
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [11:0] c, input logic l);
    int n = 0;
    while (wr_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("write_ready_wait", 64'(wr_ready), 64'(1));
    wr_valid = 1'b1; wr_addr = a; wr_rgb = c; wr_last = l;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(negedge main_clk);
      n++;
    end while (frame_shown !== 1'b1 && n < 100);
    if (frame_shown !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL pulse_timeout: no frame_shown within %0d cycles", n);
    end
  endtask

  initial begin
    int n;
    int cnt;

    // Reset held 3 cycles
    repeat (3) tick();
    reset = 1'b0;
    @(negedge main_clk);
    chk("rst_R", 64'(R), 64'(25'h1FFFFFF));
    chk("rst_G", 64'(G), 64'(25'h1FFFFFF));
    chk("rst_B", 64'(B), 64'(25'h1FFFFFF));
    chk("rst_ready", 64'(wr_ready), 64'(1));
    chk("rst_shown", 64'(frame_shown), 64'(0));
    chk("rst_err", 64'(err_addr), 64'(0));

    // addr0 full red, closes frame
    tick();
    write(5'd0, rgb_pack(4'hF, 4'h0, 4'h0), 1'b1);
    @(negedge main_clk);
    chk("ready_low_after_last", 64'(wr_ready), 64'(0));
    wait_pulse(n);
    chk("first_pulse_latency", 64'(n), 64'(27));
    @(negedge main_clk);
    chk("ready_after_pulse", 64'(wr_ready), 64'(1));
    cnt = 0;
    for (int i = 0; i < int'(PER); i++) begin
      @(negedge main_clk);
      if (R === 25'h1FFFFFE && G === 25'h1FFFFFF && B === 25'h1FFFFFF) cnt++;
    end
    chk("red0_steady", 64'(cnt), 64'(PER));

    // addr3 green level 8 -> 16 of 30 clocks lit
    write(5'd3, 12'h080, 1'b1);
    wait_pulse(n);
    @(negedge main_clk);
    cnt = 0;
    for (int i = 0; i < int'(PER); i++) begin
      @(negedge main_clk);
      if (i == 0) chk("g3_lit_at_pwm0", 64'(G[3]), 64'(0));
      if (G[3] === 1'b0) cnt++;
    end
    chk("g3_duty", 64'(cnt), 64'(16));
    chk("g3_red0", 64'(rgb_red(rgb_t'(12'hF00))), 64'(4'hF));

    // Out-of-range address still closes the frame
    write(5'd25, 12'hFFF, 1'b1);
    @(negedge main_clk);
    chk("err_set", 64'(err_addr), 64'(1));
    wait_pulse(n);
    repeat (2) @(negedge main_clk);
    chk("err_no_display_change", 64'(R), 64'(25'h1FFFFFE));

    // wr_last accepted on a period_end cycle waits a full period
    n = 0;
    do begin
      tick();
      n++;
    end while (!(m_t % PER == PER - 1 && wr_ready === 1'b1) && n < 100);
    wr_valid = 1'b1; wr_addr = 5'd1; wr_rgb = 12'h00F; wr_last = 1'b1;
    @(negedge main_clk);
    chk("no_swap_on_pe_accept", 64'(frame_shown), 64'(0));
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
    wait_pulse(n);
    chk("pe_accept_delay", 64'(n), 64'(30));
    chk("err_sticky", 64'(err_addr), 64'(1));

    // Partial frame discarded by a 1-cycle reset
    for (int i = 0; i < 10; i++) write(ADDR_W'(10 + i), 12'hFFF, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge main_clk);
    chk("rst2_R", 64'(R), 64'(25'h1FFFFFF));
    chk("rst2_G", 64'(G), 64'(25'h1FFFFFF));
    chk("rst2_B", 64'(B), 64'(25'h1FFFFFF));
    chk("rst2_ready", 64'(wr_ready), 64'(1));
    chk("rst2_err", 64'(err_addr), 64'(0));
    write(5'd7, 12'hF0F, 1'b1);
    wait_pulse(n);
    repeat (2) @(negedge main_clk);
    chk("post_rst_R", 64'(R), 64'(25'h1FFFF7F));
    chk("post_rst_G", 64'(G), 64'(25'h1FFFFFF));
    chk("post_rst_B", 64'(B), 64'(25'h1FFFF7F));

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      tick();
      reset    = ($urandom_range(0, 399) == 0);
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = ADDR_W'($urandom_range(0, 26));
      wr_rgb   = 12'($urandom);
      wr_last  = ($urandom_range(0, 7) == 0);
    end
    tick();
    reset = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
